player_shot_ctrl: RTL
=====================

Name: player_shot_ctrl

Overview:
- Sequences the player's single laser shot: accepts fire requests, launches the shot from the current player position, advances it once per frame, and retires it on a hit or on leaving the top of the play field.
- Enforces a frame-counted cooldown between shots.
- Sits between the input handler and player position block upstream, and the collision/render logic downstream.

Parameters:
- SHOT_STEP, 4: pixels the shot moves up per frame.
- SHOT_TOP, 8: minimum legal shot_y. A shot whose next position would be below this is retired as a miss.
- SHOT_OFFSET_X, 6: x offset from player_x to the shot column (sprite centre).
- SHOT_H, 4: shot height. Launch y is player_y - SHOT_H.
- COOLDOWN_FRAMES, 8: frames between shot retirement and the next allowed launch. Width 8 bits. 0 means no cooldown.

Ports:
- clk, input, 1: system clock.
- arst, input, 1: asynchronous reset, active-low (asserted at 0).
- frame, input, 1: one-cycle frame-tick pulse.
- fire, input, 1: fire button, level, already synchronised.
- player_x, input, 10: current player x.
- player_y, input, 10: current player y.
- hit, input, 1: one-cycle pulse from collision logic; the shot struck a target.
- shot_active, output, 1: shot is in flight and valid to draw and collide.
- shot_x, output, 10: shot column.
- shot_y, output, 10: shot top row.
- shot_done, output, 1: one-cycle pulse when a shot retires.
- shot_hit, output, 1: qualifies shot_done. 1 means hit, 0 means miss. Held until the next shot_done.
- ready, output, 1: high in IDLE; a shot may be launched.

Behaviour:
- Reset (arst=0, immediate, asynchronous): state IDLE, shot_active=0, shot_x=0, shot_y=0, shot_done=0, shot_hit=0, ready=1, cooldown counter=0, fire_pend=0. Reset mid-flight kills the shot with no shot_done pulse.
- fire_pend:
  - Set on any cycle with fire=1 while state is IDLE.
  - Cleared on every frame pulse, after being sampled.
  - Ignored (held at 0) in ACTIVE and COOLDOWN.
- IDLE:
  - On frame with fire_pend=1 or fire=1, the next cycle has shot_x = player_x + SHOT_OFFSET_X and shot_y = player_y - SHOT_H (10-bit, truncating).
  - That same cycle, shot_active=1, ready=0, and the state moves to ACTIVE.
- ACTIVE:
  - hit=1 on any cycle retires the shot. Next cycle: shot_active=0, shot_done=1 for one cycle, shot_hit=1. shot_x/shot_y hold their last values.
  - Otherwise, on frame: if shot_y < SHOT_TOP + SHOT_STEP, retire as a miss (shot_done=1, shot_hit=0). Else shot_y <= shot_y - SHOT_STEP, visible the cycle after frame.
  - hit and frame in the same cycle: hit wins; no movement.
- Retire: the cooldown counter is loaded with COOLDOWN_FRAMES. If COOLDOWN_FRAMES=0, go directly to IDLE; else go to COOLDOWN.
- COOLDOWN:
  - Each frame decrements the counter.
  - When the decrement reaches 0, go to IDLE; ready=1 the next cycle.
  - hit is ignored.
- hit outside ACTIVE is ignored entirely.
- Timing rules:
  - All outputs are registered.
  - Launch latency is 1 cycle after the frame.
  - Retire latency is 1 cycle after hit or frame.
- frame and fire arriving in the cycle that enters IDLE: that frame does not launch. Launch requires the state to be IDLE when frame is sampled.

Optional Feature:
- Macro: PLAYER_SHOT_EDGE_EN.
- Defined:
  - fire is edge-qualified. A launch requires a 0->1 transition of fire since the last launch, tracked by an internal armed flag.
  - The armed flag is set when fire is seen at 0 in any state. It is cleared on launch.
  - Holding fire gives exactly one shot.
- Undefined:
  - Level behaviour as above. Holding fire autofires once per cooldown period.

Test Plan:
- Launch: player_x=100, player_y=440, fire held, one frame pulse -> next cycle shot_active=1, shot_x=106, shot_y=436, ready=0.
- Miss path: after launch, pulse frame 108 times -> shot_y reaches 8 after frame 107. Frame 108 gives shot_done=1 (single cycle), shot_hit=0, shot_active=0.
- Hit vs frame: with shot in flight at y=200, assert hit and frame in the same cycle -> shot_done=1, shot_hit=1, shot_y stays 200. A later hit while not ACTIVE produces no shot_done.
- Cooldown: fire held throughout, shot retired by hit -> ready stays 0 for 8 frame pulses. Next launch occurs on frame 9, not before.
- Reset mid-flight: shot active at y=300, drive arst=0 between clock edges -> shot_active=0, shot_y=0, ready=1 immediately; no shot_done pulse.
- PLAYER_SHOT_EDGE_EN: fire held high through 3 cooldown periods -> exactly one launch. Release for one frame and press again -> second launch.

Source files
------------

// File: rtl/player_shot_ctrl_if.sv
// Purpose: groups the player shot controller's request inputs and shot status outputs.
// Latency: none; this is plain wiring.
// Backpressure: none; frame and hit are single-cycle pulses and fire is a level.
interface player_shot_ctrl_if;
    logic       frame;
    logic       fire;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       hit;
    logic       shot_active;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic       shot_done;
    logic       shot_hit;
    logic       ready;

    // Upstream/downstream environment side: drives requests and observes the shot.
    modport master (
        output frame, fire, player_x, player_y, hit,
        input  shot_active, shot_x, shot_y, shot_done, shot_hit, ready
    );

    // Controller side.
    modport slave (
        input  frame, fire, player_x, player_y, hit,
        output shot_active, shot_x, shot_y, shot_done, shot_hit, ready
    );
endinterface

// File: rtl/player_shot_ctrl.sv
// Purpose: sequences the single player laser shot (launch, per-frame climb, hit/miss retire, cooldown).
// Latency: launch and retire are visible 1 cycle after the sampling frame/hit; all outputs are registered.
// Backpressure: none; fire is latched in IDLE until the next frame, and requests outside IDLE are dropped.
// Define PLAYER_SHOT_EDGE_EN to make fire edge-qualified (one shot per press).
module player_shot_ctrl #(
    parameter int          SHOT_STEP       = 4,
    parameter int          SHOT_TOP        = 8,
    parameter int          SHOT_OFFSET_X   = 6,
    parameter int          SHOT_H          = 4,
    parameter logic [7:0]  COOLDOWN_FRAMES = 8'd8
) (
    input  logic                 clk,
    input  logic                 arst,
    player_shot_ctrl_if.slave    bus
);

    localparam logic [9:0] STEP_C   = 10'(SHOT_STEP);
    localparam logic [9:0] OFFS_X_C = 10'(SHOT_OFFSET_X);
    localparam logic [9:0] SHOT_H_C = 10'(SHOT_H);
    // A shot below this row cannot take another full step without crossing the top.
    localparam logic [9:0] MISS_LIM = 10'(SHOT_TOP + SHOT_STEP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t     state_q;
    logic [9:0] shot_x_q;
    logic [9:0] shot_y_q;
    logic       shot_active_q;
    logic       shot_done_q;
    logic       shot_hit_q;
    logic       ready_q;
    logic [7:0] cd_q;
    logic [7:0] cd_d;
    logic       fire_pend_q;
    logic       fire_ok;
    logic       launch;

`ifdef PLAYER_SHOT_EDGE_EN
    logic armed_q;

    // A press only counts once fire has been seen low since the last launch.
    assign fire_ok = bus.fire & armed_q;

    // Re-arm whenever the button is released; disarm on launch so a held button fires once.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            armed_q <= 1'b0;
        end else if (launch) begin
            armed_q <= 1'b0;
        end else if (!bus.fire) begin
            armed_q <= 1'b1;
        end
    end
`else
    // Level mode: a held button autofires once per cooldown period.
    assign fire_ok = bus.fire;
`endif

    assign launch = (state_q == IDLE) && bus.frame && (fire_pend_q || fire_ok);
    assign cd_d   = cd_q - 8'd1;

    // Shot FSM: launch on frame, climb per frame, retire on hit or top-out, then count down the cooldown.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q       <= IDLE;
            shot_x_q      <= 10'd0;
            shot_y_q      <= 10'd0;
            shot_active_q <= 1'b0;
            shot_done_q   <= 1'b0;
            shot_hit_q    <= 1'b0;
            ready_q       <= 1'b1;
            cd_q          <= 8'd0;
            fire_pend_q   <= 1'b0;
        end else begin
            shot_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.frame) begin
                        // The pending request is consumed by this frame whether or not it launches.
                        fire_pend_q <= 1'b0;
                        if (launch) begin
                            shot_x_q      <= bus.player_x + OFFS_X_C;
                            shot_y_q      <= bus.player_y - SHOT_H_C;
                            shot_active_q <= 1'b1;
                            ready_q       <= 1'b0;
                            state_q       <= ACTIVE;
                        end
                    end else if (fire_ok) begin
                        fire_pend_q <= 1'b1;
                    end
                end

                ACTIVE: begin
                    fire_pend_q <= 1'b0;
                    // A hit outranks a coincident frame: the shot retires where it was struck.
                    if (bus.hit || (bus.frame && (shot_y_q < MISS_LIM))) begin
                        shot_active_q <= 1'b0;
                        shot_done_q   <= 1'b1;
                        shot_hit_q    <= bus.hit;
                        cd_q          <= COOLDOWN_FRAMES;
                        if (COOLDOWN_FRAMES == 8'd0) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= COOLDOWN;
                        end
                    end else if (bus.frame) begin
                        shot_y_q <= shot_y_q - STEP_C;
                    end
                end

                COOLDOWN: begin
                    fire_pend_q <= 1'b0;
                    if (bus.frame) begin
                        cd_q <= cd_d;
                        if (cd_d == 8'd0) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.shot_active = shot_active_q;
    assign bus.shot_x      = shot_x_q;
    assign bus.shot_y      = shot_y_q;
    assign bus.shot_done   = shot_done_q;
    assign bus.shot_hit    = shot_hit_q;
    assign bus.ready       = ready_q;

endmodule
